// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: control/status bundle between the multicycle controller and its datapath
interface multicycle_controller_if;
  logic [15:0] IRout;
  logic        zero;
  logic        mem_ready;
  logic [2:0]  Mux1_alu_B;
  logic [2:0]  Mux2_alu_A;
  logic [1:0]  Mux3_RF_wen;
  logic [1:0]  ALU_op;
  logic        CZen;
  logic        wIR;
  logic        wT1;
  logic        wtmpA;
  logic        memRead;
  logic        memWrite;
  logic        pc_inc;
  logic        pc_load;
  logic [2:0]  counter;
  logic        mem_timeout;
  modport master (
    input  IRout, zero, mem_ready,
    output Mux1_alu_B, Mux2_alu_A, Mux3_RF_wen, ALU_op, CZen, wIR, wT1, wtmpA,
           memRead, memWrite, pc_inc, pc_load, counter, mem_timeout
  );
  modport slave (
    output IRout, zero, mem_ready,
    input  Mux1_alu_B, Mux2_alu_A, Mux3_RF_wen, ALU_op, CZen, wIR, wT1, wtmpA,
           memRead, memWrite, pc_inc, pc_load, counter, mem_timeout
  );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: FSM sequencing one RISC instruction over several cycles
module multicycle_controller #(
  parameter int MEM_WAIT_MAX = 15
) (
  input logic                    clk,
  input logic                    reset,
  multicycle_controller_if.master bus
);
  localparam int WW = $clog2(MEM_WAIT_MAX + 1);
  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, LHI, ADDR, MEM_RD, MEM_WR,
    MULTI_INIT, MULTI, MULTI_INC, BEQ, BR, JMP
  } state_t;
  state_t        state, state_n;
  logic [2:0]    counter, counter_n;
  logic [WW-1:0] wait_cnt;
  logic          timeout_r;
  logic [3:0]    op;
  logic          mask_bit, mem_state, to, rdy;
  logic [2:0]    a, b;
  logic [1:0]    rf, aop;
  logic          czen, wir, wt1, wta, mrd, mwr, pinc, pld;
  logic          unused;
  assign op       = bus.IRout[15:12];
  assign unused   = ^{bus.IRout[11:8], bus.IRout[1:0]};
  // LM/SM walk the mask from IR[7] down to IR[0]
  assign mask_bit  = bus.IRout[3'd7 - counter];
  assign mem_state = state == FETCH || state == MEM_RD || state == MEM_WR || (state == MULTI && mask_bit);
  assign to        = mem_state && wait_cnt == WW'(MEM_WAIT_MAX);
  assign rdy       = mem_state && !to && bus.mem_ready;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= FETCH;
      counter   <= '0;
      wait_cnt  <= '0;
      timeout_r <= 1'b0;
    end else begin
      state     <= state_n;
      counter   <= counter_n;
      wait_cnt  <= (!mem_state || rdy || to) ? '0 : wait_cnt + WW'(1);
      timeout_r <= timeout_r | to;
    end
  always_comb begin
    state_n   = state;
    counter_n = counter;
    a         = '0;
    b         = '0;
    rf        = '0;
    aop       = '0;
    {czen, wir, wt1, wta, mrd, mwr, pinc, pld} = '0;
    case (state)
      FETCH: begin
        mrd     = !to;
        wir     = rdy;
        pinc    = rdy;
        state_n = rdy ? DECODE : FETCH;
      end
      DECODE: case (op)
        4'b0000, 4'b0010: state_n = EXEC_R;
        4'b0001:          state_n = EXEC_I;
        4'b0011:          state_n = LHI;
        4'b0100, 4'b0101: state_n = ADDR;
        4'b0110, 4'b0111: state_n = MULTI_INIT;
        4'b1000, 4'b1001: state_n = JMP;
        4'b1100:          state_n = BEQ;
        default:          state_n = FETCH;
      endcase
      EXEC_R: begin
        a       = 3'd5;
        b       = 3'd2;
        aop     = op == 4'b0010 ? 2'b01 : 2'b00;
        czen    = 1'b1;
        rf      = 2'd2;
        state_n = FETCH;
      end
      EXEC_I: begin
        a       = 3'd5;
        b       = 3'd3;
        czen    = 1'b1;
        rf      = 2'd1;
        state_n = FETCH;
      end
      LHI: begin
        a       = 3'd2;
        rf      = 2'd1;
        state_n = FETCH;
      end
      ADDR: begin
        a       = 3'd5;
        b       = 3'd3;
        wt1     = 1'b1;
        state_n = op[0] ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mrd     = !to;
        rf      = rdy ? 2'd1 : 2'd0;
        czen    = rdy;
        state_n = (rdy || to) ? FETCH : MEM_RD;
      end
      MEM_WR: begin
        mwr     = !to;
        state_n = (rdy || to) ? FETCH : MEM_WR;
      end
      MULTI_INIT: begin
        a         = 3'd5;
        wta       = 1'b1;
        counter_n = '0;
        state_n   = MULTI;
      end
      MULTI: begin
        mrd       = mask_bit && !op[0] && !to;
        mwr       = mask_bit && op[0] && !to;
        rf        = (rdy && !op[0]) ? 2'd3 : 2'd0;
        counter_n = mask_bit ? counter : counter + 3'd1;
        state_n   = to ? FETCH : mask_bit ? (rdy ? MULTI_INC : MULTI) : (counter == 3'd7 ? FETCH : MULTI);
      end
      MULTI_INC: begin
        a         = 3'd6;
        b         = 3'd1;
        wta       = 1'b1;
        counter_n = counter + 3'd1;
        state_n   = counter == 3'd7 ? FETCH : MULTI;
      end
      BEQ: begin
        a       = 3'd5;
        b       = 3'd2;
        aop     = 2'b10;
        state_n = bus.zero ? BR : FETCH;
      end
      BR: begin
        a       = 3'd3;
        pld     = 1'b1;
        state_n = FETCH;
      end
      JMP: begin
        a       = op[0] ? 3'd0 : 3'd4;
        b       = op[0] ? 3'd2 : 3'd0;
        rf      = 2'd1;
        pld     = 1'b1;
        state_n = FETCH;
      end
      default: state_n = FETCH;
    endcase
    // reset is asynchronous, so the strobes must drop without waiting for a clock
    if (reset) {a, b, rf, aop, czen, wir, wt1, wta, mrd, mwr, pinc, pld} = '0;
  end
  assign bus.Mux2_alu_A  = a;
  assign bus.Mux1_alu_B  = b;
  assign bus.Mux3_RF_wen = rf;
  assign bus.ALU_op      = aop;
  assign bus.CZen        = czen;
  assign bus.wIR         = wir;
  assign bus.wT1         = wt1;
  assign bus.wtmpA       = wta;
  assign bus.memRead     = mrd;
  assign bus.memWrite    = mwr;
  assign bus.pc_inc      = pinc;
  assign bus.pc_load     = pld;
  assign bus.counter     = counter;
  assign bus.mem_timeout = timeout_r;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed per-cycle vectors checked through a scoreboard queue
module tb_multicycle_controller;
  typedef struct packed {
    logic [2:0] a, b;
    logic [1:0] rf, op;
    logic [7:0] f;
    logic [2:0] cnt;
    logic       to;
  } vec_t;
  localparam logic [7:0] CZ = 8'h80, WIR = 8'h40, WT1 = 8'h20, WTA = 8'h10;
  localparam logic [7:0] MRD = 8'h08, MWR = 8'h04, PINC = 8'h02, PLD = 8'h01;
  logic  clk = 1'b0;
  logic  reset = 1'b1;
  logic  exp_to = 1'b0;
  int    vectors = 0;
  int    miscompares = 0;
  vec_t  q[$];
  string nq[$];
  multicycle_controller_if bus();
  multicycle_controller #(.MEM_WAIT_MAX(15)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic vec_t v(input logic [2:0] a, input logic [2:0] b, input logic [1:0] rf,
                             input logic [1:0] op, input logic [7:0] f, input logic [2:0] cnt);
    vec_t e;
    e.a = a; e.b = b; e.rf = rf; e.op = op; e.f = f; e.cnt = cnt; e.to = 1'b0;
    return e;
  endfunction
  task automatic cyc(input logic r, input logic rdy, input logic z, input vec_t e, input string nm);
    reset = r;
    bus.mem_ready = rdy;
    bus.zero = z;
    e.to = exp_to;
    q.push_back(e);
    nq.push_back(nm);
    @(posedge clk);
    #1;
  endtask
  task automatic fetch_decode(input logic [15:0] ir);
    bus.IRout = ir;
    cyc(0, 1, 0, v(0, 0, 0, 0, WIR | MRD | PINC, 0), "fetch");
    cyc(0, 0, 0, v(0, 0, 0, 0, 0, 0), "decode");
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      vec_t  e, act;
      string nm;
      e  = q.pop_front();
      nm = nq.pop_front();
      act = {bus.Mux2_alu_A, bus.Mux1_alu_B, bus.Mux3_RF_wen, bus.ALU_op,
             bus.CZen, bus.wIR, bus.wT1, bus.wtmpA, bus.memRead, bus.memWrite, bus.pc_inc, bus.pc_load,
             bus.counter, bus.mem_timeout};
      vectors++;
      if (act !== e) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", nm, act, e);
      end
    end
  initial begin
    bus.IRout = 16'h0000;
    bus.mem_ready = 1'b0;
    bus.zero = 1'b0;
    @(posedge clk);
    #1;
    cyc(1, 0, 0, v(0, 0, 0, 0, 0, 0), "reset_outputs");
    cyc(0, 0, 0, v(0, 0, 0, 0, MRD, 0), "fetch_after_reset");
    fetch_decode(16'h0000);
    cyc(0, 0, 0, v(5, 2, 2, 0, CZ, 0), "exec_add");
    fetch_decode(16'h2000);
    cyc(0, 0, 0, v(5, 2, 2, 1, CZ, 0), "exec_ndu");
    fetch_decode(16'h1000);
    cyc(0, 0, 0, v(5, 3, 1, 0, CZ, 0), "exec_adi");
    fetch_decode(16'h3000);
    cyc(0, 0, 0, v(2, 0, 1, 0, 0, 0), "lhi");
    fetch_decode(16'h4000);
    cyc(0, 0, 0, v(5, 3, 0, 0, WT1, 0), "lw_addr");
    repeat (3) cyc(0, 0, 0, v(0, 0, 0, 0, MRD, 0), "lw_wait");
    cyc(0, 1, 0, v(0, 0, 1, 0, MRD | CZ, 0), "lw_ready");
    fetch_decode(16'h5000);
    cyc(0, 0, 0, v(5, 3, 0, 0, WT1, 0), "sw_addr");
    cyc(0, 1, 0, v(0, 0, 0, 0, MWR, 0), "sw_ready");
    fetch_decode(16'h60A0);
    cyc(0, 0, 0, v(5, 0, 0, 0, WTA, 0), "lm_init");
    cyc(0, 1, 0, v(0, 0, 3, 0, MRD, 0), "lm_rd0");
    cyc(0, 0, 0, v(6, 1, 0, 0, WTA, 0), "lm_inc0");
    cyc(0, 0, 0, v(0, 0, 0, 0, 0, 1), "lm_skip1");
    cyc(0, 1, 0, v(0, 0, 3, 0, MRD, 2), "lm_rd2");
    cyc(0, 0, 0, v(6, 1, 0, 0, WTA, 2), "lm_inc2");
    for (int i = 3; i < 8; i++) cyc(0, 0, 0, v(0, 0, 0, 0, 0, 3'(i)), "lm_skip");
    fetch_decode(16'h7081);
    cyc(0, 0, 0, v(5, 0, 0, 0, WTA, 0), "sm_init");
    cyc(0, 0, 0, v(0, 0, 0, 0, MWR, 0), "sm_wait0");
    cyc(0, 1, 0, v(0, 0, 0, 0, MWR, 0), "sm_wr0");
    cyc(0, 0, 0, v(6, 1, 0, 0, WTA, 0), "sm_inc0");
    for (int i = 1; i < 7; i++) cyc(0, 0, 0, v(0, 0, 0, 0, 0, 3'(i)), "sm_skip");
    cyc(0, 1, 0, v(0, 0, 0, 0, MWR, 7), "sm_wr7");
    cyc(0, 0, 0, v(6, 1, 0, 0, WTA, 7), "sm_inc7");
    fetch_decode(16'hC000);
    cyc(0, 0, 1, v(5, 2, 0, 2, 0, 0), "beq_cmp_taken");
    cyc(0, 0, 0, v(3, 0, 0, 0, PLD, 0), "br");
    fetch_decode(16'hC000);
    cyc(0, 0, 0, v(5, 2, 0, 2, 0, 0), "beq_cmp_not_taken");
    fetch_decode(16'h8000);
    cyc(0, 0, 0, v(4, 0, 1, 0, PLD, 0), "jal");
    fetch_decode(16'h9000);
    cyc(0, 0, 0, v(0, 2, 1, 0, PLD, 0), "jlr");
    fetch_decode(16'hF000);
    repeat (15) cyc(0, 0, 0, v(0, 0, 0, 0, MRD, 0), "to_wait");
    cyc(0, 0, 0, v(0, 0, 0, 0, 0, 0), "to_taken");
    exp_to = 1'b1;
    cyc(0, 0, 0, v(0, 0, 0, 0, MRD, 0), "to_sticky_fetch");
    fetch_decode(16'h5000);
    cyc(0, 0, 0, v(5, 3, 0, 0, WT1, 0), "sw2_addr");
    cyc(0, 0, 0, v(0, 0, 0, 0, MWR, 0), "sw2_wait");
    exp_to = 1'b0;
    cyc(1, 0, 0, v(0, 0, 0, 0, 0, 0), "reset_in_mem_wr");
    cyc(0, 0, 0, v(0, 0, 0, 0, MRD, 0), "fetch_after_reset2");
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
